apb_cmd_master: RTL and testbench

- APB3 requester that turns a simple command/response handshake into single APB transfers.
- It is the initiator counterpart to the APB-slave register front-ends in our peripherals, such as the I2C controller register block.
- Firmware-less sequencers and the bench BFM use it to program peripheral registers (address, data, count, control) and to poll status and RX data.
- One outstanding transfer at a time, with a programmable PREADY timeout.

---
 rtl/apb_cmd_master.sv | 132 +++++++++++++
 tb/tb_apb_cmd_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB3 requester: converts a command/response handshake into single APB
// transfers, one outstanding at a time, with an optional PREADY timeout.
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Last wait-counter value before an abort; unused when TIMEOUT is 0.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit              TO_EN   = (TIMEOUT != 0);

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] wait_cnt;

    logic accept;
    logic complete;
    logic abort;

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; SETUP always lasts a single cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (complete || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Combinational handshake and transfer-end decode; PREADY wins over abort.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        accept    = cmd_ready && cmd_valid;
        complete  = (state_q == ACCESS) && PREADY;
        abort     = (state_q == ACCESS) && !PREADY && TO_EN && (wait_cnt == TO_LAST);
    end

    // APB bus outputs: address/data/direction load only on accept and then hold.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            if (accept) begin
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                PWRITE  <= cmd_write;
                PADDR   <= cmd_addr;
                PWDATA  <= cmd_wdata;
            end else if (state_q == SETUP) begin
                PENABLE <= 1'b1;
            end else if (complete || abort) begin
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
            end
        end
    end

    // Wait-state counter: cleared in SETUP, counts ACCESS cycles with PREADY low.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state_q == SETUP) begin
            wait_cnt <= '0;
        end else if ((state_q == ACCESS) && !PREADY && !abort) begin
            wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    // Response: one-cycle valid pulse; payload holds until the next response.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= complete || abort;
            if (complete) begin
                rsp_rdata   <= PWRITE ? '0 : PRDATA;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (abort) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small PREADY-driving slave model.
module tb_apb_cmd_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 8;

    logic              PCLK;
    logic              PRESETn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int n_chk  = 0;
    int n_fail = 0;

    apb_cmd_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;      // ACCESS cycles the slave holds PREADY low
        logic [31:0] prdata;
        logic        pslverr;    // driven only together with PREADY=1
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_en;     // expected cycles with PSEL & PENABLE
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_xfer(input vec_t v, input string tag);
        int en_cnt;
        bit done;
        logic [31:0] rd;
        en_cnt = 0;
        done   = 1'b0;
        @(negedge PCLK);
        chk({tag, "_cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        PRDATA    = v.prdata;
        PREADY    = 1'b0;
        PSLVERR   = 1'b1;
        @(negedge PCLK);
        // SETUP cycle: new command inputs must not disturb the registered bus
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'hFFFF_FFFF;
        cmd_write = ~v.write;
        chk({tag, "_setup_psel"}, 32'(PSEL), 32'd1);
        chk({tag, "_setup_penable"}, 32'(PENABLE), 32'd0);
        chk({tag, "_paddr"}, PADDR, v.addr);
        chk({tag, "_pwdata"}, PWDATA, v.wdata);
        chk({tag, "_pwrite"}, 32'(PWRITE), 32'(v.write));
        chk({tag, "_setup_cmd_ready"}, 32'(cmd_ready), 32'd0);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (PSEL && PENABLE) en_cnt++;
                if (cmd_ready) begin
                    chk({tag, "_busy_cmd_ready"}, 32'(cmd_ready), 32'd0);
                end
                PREADY  = (en_cnt > v.waits);
                PSLVERR = PREADY ? v.pslverr : 1'b1;
            end
        end
        chk({tag, "_rsp_seen"}, 32'(done), 32'd1);
        chk({tag, "_enable_cycles"}, 32'(en_cnt), 32'(v.exp_en));
        chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
        chk({tag, "_end_psel"}, 32'(PSEL), 32'd0);
        chk({tag, "_end_penable"}, 32'(PENABLE), 32'd0);
        chk({tag, "_end_cmd_ready"}, 32'(cmd_ready), 32'd1);
        rd      = rsp_rdata;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        @(negedge PCLK);
        chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_hold"}, rsp_rdata, rd);
        chk({tag, "_paddr_hold"}, PADDR, v.addr);
    endtask

    logic [31:0] b2b_addr[3];
    logic [31:0] b2b_data[3];
    int          acc_cyc[3];

    initial begin
        //        wr    addr   wdata        waits prdata        err   exp_rd       e_err e_to en
        vecs[0] = '{1'b1, 32'h04, 32'hA5,        0, 32'hDEAD_BEEF, 1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h0C, 32'h0,         3, 32'h0000_0001, 1'b0, 32'h1,        1'b0, 1'b0, 4};
        vecs[2] = '{1'b0, 32'h14, 32'h0,         0, 32'h5A,        1'b1, 32'h5A,       1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 32'h20, 32'h0,        99, 32'h77,        1'b0, 32'h0,        1'b1, 1'b1, 4};
        vecs[4] = '{1'b1, 32'h10, 32'h1234_5678, 0, 32'h55,        1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[5] = '{1'b0, 32'h18, 32'h0,         2, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0, 3};

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        repeat (3) @(negedge PCLK);

        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_bus", {28'd0, PSEL, PENABLE, PWRITE, rsp_valid}, 32'd0);
        chk("reset_paddr", PADDR, 32'd0);
        chk("reset_pwdata", PWDATA, 32'd0);
        chk("reset_rsp", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        PRESETn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back writes with cmd_valid held high and PREADY tied high.
        b2b_addr = '{32'h00, 32'h08, 32'h10};
        b2b_data = '{32'h50, 32'h02, 32'h01};
        begin
            int  k;
            bit  accepted;
            bit  done;
            k = 0;
            done = 1'b0;
            @(negedge PCLK);
            PREADY    = 1'b1;
            PSLVERR   = 1'b0;
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = b2b_addr[0];
            cmd_wdata = b2b_data[0];
            for (int c = 0; c < 30 && k < 3; c++) begin
                accepted = cmd_ready;
                if (accepted) begin
                    acc_cyc[k] = c;
                    if (k > 0) chk($sformatf("b2b_rsp_with_accept%0d", k), 32'(rsp_valid), 32'd1);
                end
                @(negedge PCLK);
                if (accepted) begin
                    chk($sformatf("b2b_paddr%0d", k), PADDR, b2b_addr[k]);
                    chk($sformatf("b2b_pwdata%0d", k), PWDATA, b2b_data[k]);
                    k++;
                    if (k < 3) begin
                        cmd_addr  = b2b_addr[k];
                        cmd_wdata = b2b_data[k];
                    end else begin
                        cmd_valid = 1'b0;
                    end
                end
            end
            chk("b2b_all_accepted", 32'(k), 32'd3);
            chk("b2b_spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("b2b_spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
            for (int c = 0; c < 10 && !done; c++) begin
                @(negedge PCLK);
                if (rsp_valid) done = 1'b1;
            end
            chk("b2b_last_rsp", 32'(done), 32'd1);
            chk("b2b_last_err", 32'(rsp_err), 32'd0);
        end

        // Reset asserted during a waited read.
        @(negedge PCLK);
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = 32'h1111_2222;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h2C;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_mid_in_access", {30'd0, PSEL, PENABLE}, 32'd3);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("rst_mid_psel", 32'(PSEL), 32'd0);
        chk("rst_mid_penable", 32'(PENABLE), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_paddr", PADDR, 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        PREADY = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 5; c++) begin
                if (rsp_valid || PSEL) pulses++;
                @(negedge PCLK);
            end
            chk("rst_release_no_activity", 32'(pulses), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
